side_buffer_param: RTL and testbench

- Parametrised next-generation minBD side buffer: circular FIFO holding deflected flits for later re-injection into the router pipeline.
- Accepts up to two writes per cycle (redirect stage, eject-to-side-buffer stage) and one pop per cycle (side-buffer inject stage).
- Generates full/empty/starve flags that feed the redirect and inject arbiters.
- Adds configurable depth/width, an occupancy count, a programmable starvation threshold and an overflow error flag.

---
 rtl/minbd_pkg.sv | 15 +
 rtl/side_buffer_param_if.sv | 43 ++++
 rtl/sat_counter.sv | 41 ++++
 rtl/side_buffer_param.sv | 133 +++++++++++++
 tb/tb_side_buffer_param.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/minbd_pkg.sv
// minBD shared types and widths for the router pipeline.
// Flit widths are macros so legacy code keeps using them.
`ifndef MINBD_PKG_SV
`define MINBD_PKG_SV
`define WIDTH_FLIT_INT 40
`define WIDTH_FLIT_EXT 42

package minbd_pkg;

  typedef logic [`WIDTH_FLIT_INT-1:0] flit_int_t;

  localparam int SIDE_BUF_DEPTH = 4;

endpackage
`endif

// File: rtl/side_buffer_param_if.sv
// Side buffer port bundle: two writers, one popper, status flags.
// master = router pipeline, slave = side buffer.
interface side_buffer_param_if
  import minbd_pkg::*;
#(
  parameter int WIDTH = `WIDTH_FLIT_INT,
  parameter int DEPTH = SIDE_BUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) ();

  logic             redirect_gnt;
  logic [WIDTH-1:0] din_redirect;
  logic             eject_vld;
  logic [WIDTH-1:0] din_eject;
  logic             inject_gnt;
  logic [WIDTH-1:0] dout_inject;
  logic             full;
  logic             empty;
  logic             starve;
  logic [CNT_W-1:0] count;
  logic             ovf_err;
  logic [31:0]      stat_wr_cnt;
  logic [31:0]      stat_starve_cyc;

  modport master (
    output redirect_gnt, din_redirect,
    output eject_vld, din_eject,
    output inject_gnt,
    input  dout_inject, full, empty,
    input  starve, count, ovf_err,
    input  stat_wr_cnt, stat_starve_cyc
  );

  modport slave (
    input  redirect_gnt, din_redirect,
    input  eject_vld, din_eject,
    input  inject_gnt,
    output dout_inject, full, empty,
    output starve, count, ovf_err,
    output stat_wr_cnt, stat_starve_cyc
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; step size 0..2^IW-1.
// Priority: rst, then clr, then increment.
module sat_counter #(
  parameter int            W   = 8,
  parameter int            IW  = 1,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(inc);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (sum > {1'b0, MAX}) begin
      cnt_d = MAX;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/side_buffer_param.sv
// minBD side buffer: circular FIFO, two writes + one pop per cycle.
// Define SIDE_BUF_STATS_EN to build write/starve statistics counters.
module side_buffer_param
  import minbd_pkg::*;
#(
  parameter int WIDTH     = `WIDTH_FLIT_INT,
  parameter int DEPTH     = SIDE_BUF_DEPTH,
  parameter int STARVE_TH = 8,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                n_rst,
  side_buffer_param_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [7:0]     TH_C    = 8'(STARVE_TH);

  typedef logic [WIDTH-1:0] word_t;

  word_t            mem_q [DEPTH];
  word_t            mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    wr2_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             pop, acc_r, acc_e, drop;
  logic [1:0]       n_acc;
  logic [CNT_W:0]   occ;
  logic [7:0]       stv_cnt;
  logic             starve;

  // Pop frees its slot before writes are checked against capacity.
  always_comb begin
    pop     = bus.inject_gnt & ~empty_q;
    occ     = {1'b0, count_q} - (CNT_W+1)'(pop);
    acc_r   = bus.redirect_gnt & (occ < DEPTH_C);
    acc_e   = bus.eject_vld
            & ((occ + (CNT_W+1)'(acc_r)) < DEPTH_C);
    drop    = (bus.redirect_gnt & ~acc_r)
            | (bus.eject_vld & ~acc_e);
    n_acc   = {1'b0, acc_r} + {1'b0, acc_e};
    wr2_ptr = wr_ptr_q + PW'(acc_r);

    mem_d = mem_q;
    if (acc_r) mem_d[wr_ptr_q] = bus.din_redirect;
    if (acc_e) mem_d[wr2_ptr]  = bus.din_eject;

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(n_acc);
    count_d  = CNT_W'(occ + (CNT_W+1)'(n_acc));
    full_d   = count_d >= CNT_W'(DEPTH - 1);
    empty_d  = count_d == '0;
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  sat_counter #(
    .W   (8),
    .IW  (1),
    .MAX (TH_C)
  ) u_starve_cnt (
    .clk (clk),
    .rst (n_rst),
    .clr (empty_q | bus.inject_gnt),
    .inc (~empty_q & ~bus.inject_gnt),
    .cnt (stv_cnt)
  );

  assign starve = stv_cnt == TH_C;

  assign bus.dout_inject = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.starve      = starve;
  assign bus.count       = count_q;
  assign bus.ovf_err     = ovf_q;

`ifdef SIDE_BUF_STATS_EN
  sat_counter #(
    .W   (32),
    .IW  (2),
    .MAX (32'hFFFF_FFFF)
  ) u_stat_wr (
    .clk (clk),
    .rst (n_rst),
    .clr (1'b0),
    .inc (n_acc),
    .cnt (bus.stat_wr_cnt)
  );

  sat_counter #(
    .W   (32),
    .IW  (1),
    .MAX (32'hFFFF_FFFF)
  ) u_stat_starve (
    .clk (clk),
    .rst (n_rst),
    .clr (1'b0),
    .inc (starve),
    .cnt (bus.stat_starve_cyc)
  );
`else
  assign bus.stat_wr_cnt     = '0;
  assign bus.stat_starve_cyc = '0;
`endif

endmodule

// File: tb/tb_side_buffer_param.sv
// Directed, table-driven bench for side_buffer_param.
// DEPTH=4, STARVE_TH=8, WIDTH=40.
module tb_side_buffer_param;
  import minbd_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [39:0] Z = 40'h0;

`ifdef SIDE_BUF_STATS_EN
  localparam logic [31:0] EXP_WR = 32'd5;
  localparam logic [31:0] EXP_SC = 32'd3;
`else
  localparam logic [31:0] EXP_WR = 32'd0;
  localparam logic [31:0] EXP_SC = 32'd0;
`endif

  typedef struct {
    logic        rst;
    logic        rg;
    logic [39:0] dr;
    logic        ev;
    logic [39:0] de;
    logic        ig;
    logic [39:0] dout;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        stv;
  } vec_t;

  logic clk;
  logic n_rst;
  int   n_chk;
  int   n_fail;
  vec_t v [23];

  side_buffer_param_if #(.WIDTH(40), .DEPTH(4)) sb ();

  side_buffer_param #(
    .WIDTH     (40),
    .DEPTH     (4),
    .STARVE_TH (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (sb)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic rst, logic rg, logic [39:0] dr,
    logic ev, logic [39:0] de, logic ig,
    logic [39:0] dout, logic [2:0] cnt,
    logic full, logic empty, logic ovf, logic stv
  );
    vec_t r;
    r.rst = rst; r.rg = rg; r.dr = dr;
    r.ev = ev; r.de = de; r.ig = ig;
    r.dout = dout; r.cnt = cnt;
    r.full = full; r.empty = empty;
    r.ovf = ovf; r.stv = stv;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(
    logic rst, logic rg, logic [39:0] dr,
    logic ev, logic [39:0] de, logic ig
  );
    n_rst           = rst;
    sb.redirect_gnt = rg;
    sb.din_redirect = dr;
    sb.eject_vld    = ev;
    sb.din_eject    = de;
    sb.inject_gnt   = ig;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(O, O, Z, O, Z, O);
  endtask

  task automatic check_state(
    string tag, logic [39:0] dout, logic [2:0] cnt,
    logic full, logic empty, logic ovf, logic stv
  );
    chk({tag, " dout"},   64'(sb.dout_inject), 64'(dout));
    chk({tag, " count"},  64'(sb.count),       64'(cnt));
    chk({tag, " full"},   64'(sb.full),        64'(full));
    chk({tag, " empty"},  64'(sb.empty),       64'(empty));
    chk({tag, " ovf"},    64'(sb.ovf_err),     64'(ovf));
    chk({tag, " starve"}, 64'(sb.starve),      64'(stv));
  endtask

  initial begin
    clk    = 1'b0;
    n_rst  = 1'b1;
    n_chk  = 0;
    n_fail = 0;

    //        rst rg  dr        ev  de        ig | dout      cnt  fu em ov st
    v[0]  = mk(O, I, 40'hA5, O, Z,      O, 40'hA5, 3'd1, O, O, O, O);
    v[1]  = mk(O, O, Z,      O, Z,      I, Z,      3'd0, O, I, O, O);
    v[2]  = mk(O, I, 40'h11, I, 40'h22, O, 40'h11, 3'd2, O, O, O, O);
    v[3]  = mk(O, I, 40'h33, I, 40'h44, O, 40'h11, 3'd4, I, O, O, O);
    v[4]  = mk(O, O, Z,      O, Z,      I, 40'h22, 3'd3, I, O, O, O);
    v[5]  = mk(O, O, Z,      O, Z,      I, 40'h33, 3'd2, O, O, O, O);
    v[6]  = mk(O, O, Z,      O, Z,      I, 40'h44, 3'd1, O, O, O, O);
    v[7]  = mk(O, O, Z,      O, Z,      I, Z,      3'd0, O, I, O, O);
    v[8]  = mk(O, I, 40'h55, O, Z,      O, 40'h55, 3'd1, O, O, O, O);
    v[9]  = mk(O, I, 40'h66, I, 40'h77, O, 40'h55, 3'd3, I, O, O, O);
    v[10] = mk(O, I, 40'h88, I, 40'h99, O, 40'h55, 3'd4, I, O, I, O);
    v[11] = mk(O, O, Z,      O, Z,      I, 40'h66, 3'd3, I, O, I, O);
    v[12] = mk(O, I, 40'hAA, I, 40'hBB, I, 40'h77, 3'd4, I, O, I, O);
    v[13] = mk(I, O, Z,      O, Z,      O, Z,      3'd0, O, I, O, O);
    v[14] = mk(O, I, 40'h01, O, Z,      O, 40'h01, 3'd1, O, O, O, O);
    v[15] = mk(O, I, 40'h02, I, 40'h03, O, 40'h01, 3'd3, I, O, O, O);
    v[16] = mk(O, I, 40'h04, I, 40'h05, I, 40'h02, 3'd4, I, O, O, O);
    v[17] = mk(O, O, Z,      O, Z,      I, 40'h03, 3'd3, I, O, O, O);
    v[18] = mk(O, O, Z,      O, Z,      I, 40'h04, 3'd2, O, O, O, O);
    v[19] = mk(O, O, Z,      O, Z,      I, 40'h05, 3'd1, O, O, O, O);
    v[20] = mk(O, O, Z,      O, Z,      I, Z,      3'd0, O, I, O, O);
    v[21] = mk(O, O, Z,      O, Z,      I, Z,      3'd0, O, I, O, O);
    v[22] = mk(O, O, Z,      I, 40'h66, O, 40'h66, 3'd1, O, O, O, O);

    step(I, O, Z, O, Z, O);
    step(I, O, Z, O, Z, O);
    check_state("reset", Z, 3'd0, O, I, O, O);
    chk("reset stat_wr", 64'(sb.stat_wr_cnt), 64'd0);
    chk("reset stat_sc", 64'(sb.stat_starve_cyc), 64'd0);

    for (int i = 0; i < 23; i++) begin
      step(v[i].rst, v[i].rg, v[i].dr, v[i].ev, v[i].de, v[i].ig);
      check_state($sformatf("row%0d", i), v[i].dout, v[i].cnt,
                  v[i].full, v[i].empty, v[i].ovf, v[i].stv);
    end

    // One entry left un-granted: starve after 8 edges, saturates.
    for (int i = 1; i <= 7; i++) begin
      idle();
      check_state($sformatf("stv_idle%0d", i),
                  40'h66, 3'd1, O, O, O, O);
    end
    idle();
    check_state("stv_on", 40'h66, 3'd1, O, O, O, I);
    idle();
    check_state("stv_hold", 40'h66, 3'd1, O, O, O, I);
    step(O, O, Z, O, Z, I);
    check_state("stv_pop", Z, 3'd0, O, I, O, O);

    // Reset while starving clears every flag.
    step(O, I, 40'h77, O, Z, O);
    for (int i = 0; i < 8; i++) idle();
    check_state("stv_again", 40'h77, 3'd1, O, O, O, I);
    step(I, O, Z, O, Z, O);
    check_state("stv_reset", Z, 3'd0, O, I, O, O);

    // Statistics: 5 accepted writes, then 3 starved cycles.
    step(O, I, 40'h10, O, Z, O);
    step(O, I, 40'h20, I, 40'h30, O);
    step(O, I, 40'h40, O, Z, I);
    step(O, I, 40'h50, O, Z, I);
    check_state("stat_wr", 40'h30, 3'd3, I, O, O, O);
    for (int i = 0; i < 11; i++) idle();
    check_state("stat_stv", 40'h30, 3'd3, I, O, O, I);
    chk("stat_wr_cnt", 64'(sb.stat_wr_cnt), 64'(EXP_WR));
    chk("stat_starve_cyc", 64'(sb.stat_starve_cyc), 64'(EXP_SC));
    step(I, O, Z, O, Z, O);
    chk("stat_wr clr", 64'(sb.stat_wr_cnt), 64'd0);
    chk("stat_sc clr", 64'(sb.stat_starve_cyc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
